// File: rtl/clk_div_detector_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
//   Shared types and constants for the divided-clock detector.
//   det_state_t : measurement FSM states
//   div_code_t  : divide-ratio classification reported on div_code
//   DIVn_PERIOD : nominal rise-to-rise periods of the recognised dividers
// -----------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } det_state_t;

  typedef enum logic [1:0] {
    DIV_NONE = 2'd0,
    DIV_2    = 2'd1,
    DIV_4    = 2'd2,
    DIV_6    = 2'd3
  } div_code_t;

  localparam int DIV2_PERIOD = 2;
  localparam int DIV4_PERIOD = 4;
  localparam int DIV6_PERIOD = 6;

endpackage

// File: rtl/clk_div_detector_if.sv
// -----------------------------------------------------------------------------
// clk_div_detector_if
//   Bundles the observed divided clock and the measurement results.
//   sig_in     : divided signal, synchronous to clk
//   period     : last rise-to-rise period (clk cycles)
//   high_time  : high cycles within that period
//   meas_valid : one-cycle pulse when period/high_time update
//   div_code   : 0=other, 1=div2, 2=div4, 3=div6
//   locked     : repeated identical measurements seen
//   timeout    : sticky stall indication
//   master = source/observer side, slave = detector side.
// -----------------------------------------------------------------------------
interface clk_div_detector_if #(
  parameter int CNT_W = 8
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic [1:0]       div_code;
  logic             locked;
  logic             timeout;

  modport master (
    output sig_in,
    input  period, high_time, meas_valid, div_code, locked, timeout
  );

  modport slave (
    input  sig_in,
    output period, high_time, meas_valid, div_code, locked, timeout
  );
endinterface

// File: rtl/clk_div_detector_sig_edge_detect.sv
// -----------------------------------------------------------------------------
// sig_edge_detect
//   Registers the previous sample of i_sig and flags rising/falling edges.
//   clk    : clock
//   resetn : synchronous, active-low reset
//   i_sig  : sampled signal
//   o_rise : i_sig is 1 now and was 0 last cycle
//   o_fall : i_sig is 0 now and was 1 last cycle
// -----------------------------------------------------------------------------
module sig_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_sig_prev;

  // Reset value 1: a signal already high when reset releases is not a rise.
  always_ff @(posedge clk) begin
    if (!resetn) r_sig_prev <= 1'b1;
    else         r_sig_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig_prev;
  assign o_fall = ~i_sig & r_sig_prev;

endmodule

// File: rtl/clk_div_detector.sv
// -----------------------------------------------------------------------------
// clk_div_detector
//   Measures period and high time of a divided clock in clk cycles,
//   classifies div2/div4/div6 (50% duty), asserts lock after LOCK_CNT
//   identical measurements and flags a stalled input.
//   clk    : clock
//   resetn : synchronous, active-low reset
//   bus    : clk_div_detector_if.slave (sig_in in, measurement results out)
// -----------------------------------------------------------------------------
module clk_div_detector
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 3
) (
  input logic               clk,
  input logic               resetn,
  clk_div_detector_if.slave bus
);

  localparam int               MATCH_W = $clog2(LOCK_CNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_M = MATCH_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] P_DIV2  = CNT_W'(DIV2_PERIOD);
  localparam logic [CNT_W-1:0] P_DIV4  = CNT_W'(DIV4_PERIOD);
  localparam logic [CNT_W-1:0] P_DIV6  = CNT_W'(DIV6_PERIOD);

  // Nonzero only for exact 50% duty at one of the recognised periods.
  function automatic div_code_t classify(input logic [CNT_W-1:0] p,
                                         input logic [CNT_W-1:0] h);
    logic [CNT_W:0] h2;
    div_code_t      code;
    h2   = {h, 1'b0};
    code = DIV_NONE;
    if (h2 == {1'b0, p}) begin
      if      (p == P_DIV2) code = DIV_2;
      else if (p == P_DIV4) code = DIV_4;
      else if (p == P_DIV6) code = DIV_6;
    end
    return code;
  endfunction

  det_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_cap;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_meas_valid;
  div_code_t        r_div_code;
  logic             r_locked;
  logic             r_timeout;
  logic [MATCH_W-1:0] r_match;
  logic             r_have_prev;

  logic             w_rise;
  logic             w_fall;
  logic             w_sat;
  logic             w_meas;
  logic             w_stall;
  logic             w_same;
  logic [MATCH_W-1:0] w_match_nxt;

  sig_edge_detect u_edge (
    .clk    (clk),
    .resetn (resetn),
    .i_sig  (bus.sig_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_sat  = (r_cnt == CNT_MAX);
  assign w_meas = (r_state == LOW) && w_rise;
  // An edge that advances the FSM wins over saturation in the same cycle.
  assign w_stall = w_sat && (((r_state == HIGH) && !w_fall) ||
                             ((r_state == LOW)  && !w_rise));
  // r_period/r_high_time hold the previous pair; r_have_prev gates the
  // first measurement after IDLE, which always restarts the match count.
  assign w_same = r_have_prev && (r_cnt == r_period) &&
                  (r_high_cap == r_high_time);

  always_comb begin
    w_match_nxt = MATCH_W'(1);
    if (w_same) w_match_nxt = (r_match == LOCK_M) ? LOCK_M : r_match + 1'b1;
  end

  // Cycles since the last rise, saturating.
  always_ff @(posedge clk) begin
    if (!resetn)     r_cnt <= '0;
    else if (w_rise) r_cnt <= CNT_W'(1);
    else if (!w_sat) r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_high_cap   <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_div_code   <= DIV_NONE;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
      r_match      <= '0;
      r_have_prev  <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (w_meas) begin
        r_period     <= r_cnt;
        r_high_time  <= r_high_cap;
        r_meas_valid <= 1'b1;
        r_div_code   <= classify(r_cnt, r_high_cap);
        r_match      <= w_match_nxt;
        r_locked     <= (w_match_nxt == LOCK_M);
        r_have_prev  <= 1'b1;
        r_timeout    <= 1'b0;
        r_state      <= HIGH;
      end else if (w_stall) begin
        r_timeout    <= 1'b1;
        r_locked     <= 1'b0;
        r_match      <= '0;
        r_have_prev  <= 1'b0;
        r_state      <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (w_rise) r_state <= HIGH;
          HIGH: if (w_fall) begin
                  r_high_cap <= r_cnt;
                  r_state    <= LOW;
                end
          LOW:  ;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.period     = r_period;
  assign bus.high_time  = r_high_time;
  assign bus.meas_valid = r_meas_valid;
  assign bus.div_code   = r_div_code;
  assign bus.locked     = r_locked;
  assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_clk_div_detector.sv
// -----------------------------------------------------------------------------
// tb_clk_div_detector
//   Directed and randomized stimulus for clk_div_detector. A reference model
//   works from edge timestamps: period = time between rises, high = time from
//   rise to fall, stall = no edge for 2**CNT_W-1 cycles while tracking.
// -----------------------------------------------------------------------------
module tb_clk_div_detector;

  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 3;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  clk_div_detector_if #(.CNT_W(CNT_W)) bus ();

  clk_div_detector #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state (edge index based).
  int k = 0;
  bit m_prev = 1'b1, m_track = 1'b0, m_fell = 1'b0;
  int m_rise_t = 0, m_fall_t = 0;
  int m_period = 0, m_high = 0, m_code = 0, m_match = 0;
  int m_pp = 0, m_ph = 0, m_nmeas = 0;
  bit m_mv = 1'b0, m_locked = 1'b0, m_timeout = 1'b0, m_have_prev = 1'b0;
  int pos = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit s, input bit rn);
    bit rise, fall;
    int p, h;
    k++;
    if (!rn) begin
      m_prev = 1'b1; m_track = 1'b0; m_fell = 1'b0;
      m_period = 0; m_high = 0; m_code = 0; m_match = 0;
      m_mv = 1'b0; m_locked = 1'b0; m_timeout = 1'b0; m_have_prev = 1'b0;
      return;
    end
    rise = s && !m_prev;
    fall = !s && m_prev;
    m_prev = s;
    m_mv = 1'b0;
    if (rise) begin
      if (m_track && m_fell) begin
        p = k - m_rise_t;
        if (p > MAXC) p = MAXC;
        h = m_fall_t - m_rise_t;
        m_code = (2 * h == p && (p == 2 || p == 4 || p == 6)) ? p / 2 : 0;
        if (m_have_prev && p == m_pp && h == m_ph)
          m_match = (m_match + 1 > LOCK_CNT) ? LOCK_CNT : m_match + 1;
        else
          m_match = 1;
        m_locked = (m_match == LOCK_CNT);
        m_have_prev = 1'b1; m_pp = p; m_ph = h;
        m_period = p; m_high = h; m_mv = 1'b1; m_timeout = 1'b0;
        m_nmeas++;
      end
      m_track = 1'b1; m_fell = 1'b0; m_rise_t = k;
    end else if (m_track && fall && !m_fell) begin
      m_fell = 1'b1; m_fall_t = k;
    end else if (m_track && (k - m_rise_t) >= MAXC) begin
      m_timeout = 1'b1; m_locked = 1'b0; m_match = 0;
      m_have_prev = 1'b0; m_track = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("period",     bus.period,     m_period);
    chk("high_time",  bus.high_time,  m_high);
    chk("meas_valid", bus.meas_valid, m_mv);
    chk("div_code",   bus.div_code,   m_code);
    chk("locked",     bus.locked,     m_locked);
    chk("timeout",    bus.timeout,    m_timeout);
  endtask

  // Drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic step(input bit s, input bit rn);
    bus.sig_in = s;
    resetn     = rn;
    @(posedge clk);
    model_update(s, rn);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input bit s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b0);
    pos = 0;
  endtask

  // Step a repeating pattern (LSB first) until the target measurement count
  // is reached in a measurement cycle.
  task automatic run_until(input logic [15:0] pat, input int len,
                           input int target);
    int n;
    n = 0;
    while (!(m_nmeas >= target && m_mv)) begin
      if (n >= 200) begin
        chk("run_until_bound", 32'd0, 32'd1);
        return;
      end
      step(pat[pos], 1'b1);
      pos = (pos + 1) % len;
      n++;
    end
  endtask

  task automatic finish_rep(input logic [15:0] pat, input int len);
    while (pos != 0) begin
      step(pat[pos], 1'b1);
      pos = (pos + 1) % len;
    end
  endtask

  logic [15:0] P_DIV2, P_DIV4, P_DIV6, P_Q25;

  initial begin
    P_DIV2 = 16'b10;
    P_DIV4 = 16'b0110;
    P_DIV6 = 16'b001110;
    P_Q25  = 16'b0001;
    bus.sig_in = 1'b1;

    // Reset state
    do_reset(1'b1, 3);
    chk("rst_period", bus.period, 0);
    chk("rst_mv",     bus.meas_valid, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_timeout", bus.timeout, 0);

    // div2
    m_nmeas = 0;
    run_until(P_DIV2, 2, 2);
    chk("t1_locked_meas2", bus.locked, 0);
    run_until(P_DIV2, 2, 3);
    chk("t1_locked_meas3", bus.locked, 1);
    chk("t1_period", bus.period, 2);
    chk("t1_high", bus.high_time, 1);
    chk("t1_code", bus.div_code, 1);
    finish_rep(P_DIV2, 2);

    // div4, then switch to div6
    do_reset(1'b0, 2);
    m_nmeas = 0;
    run_until(P_DIV4, 4, 3);
    chk("t2_div4_period", bus.period, 4);
    chk("t2_div4_high", bus.high_time, 2);
    chk("t2_div4_code", bus.div_code, 2);
    chk("t2_div4_locked", bus.locked, 1);
    finish_rep(P_DIV4, 4);
    m_nmeas = 0;
    run_until(P_DIV6, 6, 2);
    chk("t2_div6_first_locked", bus.locked, 0);
    chk("t2_div6_period", bus.period, 6);
    chk("t2_div6_high", bus.high_time, 3);
    chk("t2_div6_code", bus.div_code, 3);
    run_until(P_DIV6, 6, 3);
    chk("t2_div6_second_locked", bus.locked, 0);
    run_until(P_DIV6, 6, 4);
    chk("t2_div6_relock", bus.locked, 1);
    finish_rep(P_DIV6, 6);

    // 25% duty
    do_reset(1'b0, 2);
    m_nmeas = 0;
    run_until(P_Q25, 4, 3);
    chk("t3_period", bus.period, 4);
    chk("t3_high", bus.high_time, 1);
    chk("t3_code", bus.div_code, 0);
    chk("t3_locked", bus.locked, 1);
    finish_rep(P_Q25, 4);

    // Stall low, then recover with div2
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1);
    chk("t4_timeout", bus.timeout, 1);
    chk("t4_locked", bus.locked, 0);
    pos = 0;
    m_nmeas = 0;
    run_until(P_DIV2, 2, 1);
    chk("t4_timeout_clear", bus.timeout, 0);
    chk("t4_mv", bus.meas_valid, 1);
    finish_rep(P_DIV2, 2);

    // High through reset: first measurement only after fall + two rises
    do_reset(1'b1, 3);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      chk("t5_hold_mv", bus.meas_valid, 0);
    end
    step(1'b0, 1'b1); chk("t5_fall_mv", bus.meas_valid, 0);
    step(1'b1, 1'b1); chk("t5_rise1_mv", bus.meas_valid, 0);
    step(1'b0, 1'b1); chk("t5_fall2_mv", bus.meas_valid, 0);
    step(1'b1, 1'b1);
    chk("t5_rise2_mv", bus.meas_valid, 1);
    chk("t5_rise2_period", bus.period, 2);
    chk("t5_rise2_high", bus.high_time, 1);

    // Reset in the middle of HIGH on a locked div6 stream
    do_reset(1'b0, 2);
    m_nmeas = 0;
    run_until(P_DIV6, 6, 3);
    chk("t6_locked_before", bus.locked, 1);
    step(P_DIV6[pos], 1'b1);
    step(1'b1, 1'b0);
    chk("t6_rst_period", bus.period, 0);
    chk("t6_rst_high", bus.high_time, 0);
    chk("t6_rst_code", bus.div_code, 0);
    chk("t6_rst_locked", bus.locked, 0);
    pos = 0;
    m_nmeas = 0;
    run_until(P_DIV6, 6, 2);
    chk("t6_relock_meas2", bus.locked, 0);
    run_until(P_DIV6, 6, 3);
    chk("t6_relock_meas3", bus.locked, 1);
    finish_rep(P_DIV6, 6);

    // Stall high: saturation while in HIGH
    for (int i = 0; i < 265; i++) step(1'b1, 1'b1);
    chk("t7_timeout_high", bus.timeout, 1);

    // Randomized segments, checked every cycle against the model
    for (int seg = 0; seg < 14; seg++) begin
      int hi, lo, reps, mode;
      hi   = $urandom_range(1, 5);
      lo   = $urandom_range(1, 5);
      reps = $urandom_range(3, 8);
      mode = $urandom_range(0, 5);
      if (mode == 0) begin
        for (int i = 0; i < 24; i++) step(1'($urandom_range(0, 1)), 1'b1);
      end else if (mode == 1) begin
        do_reset(1'($urandom_range(0, 1)), 2);
      end else begin
        for (int r = 0; r < reps; r++) begin
          for (int i = 0; i < hi; i++) step(1'b1, 1'b1);
          for (int i = 0; i < lo; i++) step(1'b0, 1'b1);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
